// File: rtl/con_eval_unit.sv
// con_eval_unit: pipelined branch-condition evaluator for the CON path.
// Latency: con_out/con_valid update on the second edge after a con_in capture.
// Backpressure: none; accepts one capture per cycle, flush kills stage 1 only.
// Ports: clk/clr (async active-high reset), con_in + bus_mux_out + ir_cond
//   (capture), flush (sync kill), con_out/con_valid/busy (results),
//   taken_cnt/eval_cnt (statistics, built only when CON_STATS_EN is defined).
// Optional feature macro: CON_STATS_EN (saturating taken/eval counters).
module con_eval_unit #(
  parameter int DATA_W   = 32,
  parameter int EXT_COND = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              con_in,
  input  logic [DATA_W-1:0] bus_mux_out,
  input  logic [2:0]        ir_cond,
  input  logic              flush,
  output logic              con_out,
  output logic              con_valid,
  output logic              busy,
  output logic [STAT_W-1:0] taken_cnt,
  output logic [STAT_W-1:0] eval_cnt
);

  // Stage 1 capture registers
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_opnd_q,  s1_opnd_d;
  logic [2:0]        s1_code_q,  s1_code_d;

  // Stage 2 result registers
  logic con_out_q,   con_out_d;
  logic con_valid_q, con_valid_d;

  logic zero, neg, eval_res;

  // Stage 1: flush wins over a simultaneous capture.
  always_comb begin
    s1_valid_d = con_in & ~flush;
    s1_opnd_d  = s1_opnd_q;
    s1_code_d  = s1_code_q;
    if (con_in && !flush) begin
      s1_opnd_d = bus_mux_out;
      s1_code_d = ir_cond;
      // Legacy 4-code set: the top code bit is ignored.
      if (EXT_COND == 0) s1_code_d[2] = 1'b0;
    end
  end

  // Condition evaluation on the stage-1 operand.
  always_comb begin
    zero     = ~|s1_opnd_q;
    neg      = s1_opnd_q[DATA_W-1];
    eval_res = 1'b0;
    case (s1_code_q)
      3'b000:  eval_res = zero;
      3'b001:  eval_res = ~zero;
      3'b010:  eval_res = ~neg;
      3'b011:  eval_res = neg;
      3'b100:  eval_res = ~neg & ~zero;
      3'b101:  eval_res = neg | zero;
      3'b110:  eval_res = 1'b1;
      default: eval_res = 1'b0;
    endcase
  end

  // Stage 2: a flush on this edge also kills the entry about to leave stage 1,
  // so it never produces a con_valid.
  always_comb begin
    con_valid_d = s1_valid_q & ~flush;
    con_out_d   = con_out_q;
    if (con_valid_d) con_out_d = eval_res;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_valid_q  <= 1'b0;
      s1_opnd_q   <= '0;
      s1_code_q   <= '0;
      con_out_q   <= 1'b0;
      con_valid_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opnd_q   <= s1_opnd_d;
      s1_code_q   <= s1_code_d;
      con_out_q   <= con_out_d;
      con_valid_q <= con_valid_d;
    end
  end

  assign con_out   = con_out_q;
  assign con_valid = con_valid_q;
  assign busy      = s1_valid_q;

`ifdef CON_STATS_EN
  logic [STAT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [STAT_W-1:0] eval_cnt_q,  eval_cnt_d;

  // Counters step with each result update and stick at all-ones.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    eval_cnt_d  = eval_cnt_q;
    if (con_valid_d) begin
      if (eval_cnt_q != {STAT_W{1'b1}}) eval_cnt_d = eval_cnt_q + 1'b1;
      if (eval_res && (taken_cnt_q != {STAT_W{1'b1}}))
        taken_cnt_d = taken_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      taken_cnt_q <= '0;
      eval_cnt_q  <= '0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
      eval_cnt_q  <= eval_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
  assign eval_cnt  = eval_cnt_q;
`else
  assign taken_cnt = '0;
  assign eval_cnt  = '0;
`endif

endmodule

// File: tb/tb_con_eval_unit.sv
module tb_con_eval_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic        con_in;
  logic [31:0] bus_mux_out;
  logic [2:0]  ir_cond;
  logic        flush;
  logic        con_out, con_valid, busy;
  logic [3:0]  taken_cnt, eval_cnt;
  logic        leg_out, leg_valid, leg_busy;
  logic [3:0]  leg_taken, leg_eval;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  con_eval_unit #(.DATA_W(32), .EXT_COND(1), .STAT_W(4)) dut (
    .clk(clk), .clr(clr), .con_in(con_in), .bus_mux_out(bus_mux_out),
    .ir_cond(ir_cond), .flush(flush), .con_out(con_out),
    .con_valid(con_valid), .busy(busy), .taken_cnt(taken_cnt),
    .eval_cnt(eval_cnt)
  );

  con_eval_unit #(.DATA_W(32), .EXT_COND(0), .STAT_W(4)) dut_leg (
    .clk(clk), .clr(clr), .con_in(con_in), .bus_mux_out(bus_mux_out),
    .ir_cond(ir_cond), .flush(flush), .con_out(leg_out),
    .con_valid(leg_valid), .busy(leg_busy), .taken_cnt(leg_taken),
    .eval_cnt(leg_eval)
  );

  // Reference: conditions as signed comparisons against zero.
  function automatic logic ref_eval(input logic [31:0] v, input logic [2:0] c);
    int s;
    s = $signed(v);
    case (c)
      3'd0: return s == 0;
      3'd1: return s != 0;
      3'd2: return s >= 0;
      3'd3: return s < 0;
      3'd4: return s > 0;
      3'd5: return s <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    con_in = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; idle(); bus_mux_out = '0; ir_cond = 3'd0;
    step(); step();
    checks++;
    if (con_out !== 1'b0 || con_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: out=%b vld=%b busy=%b required 0 0 0", con_out, con_valid, busy);
    end
    clr = 1'b0;
    // Stream (0,EQ) so con_out goes to 1 and work is in flight.
    con_in = 1'b1; bus_mux_out = '0; ir_cond = 3'd0;
    step(); step(); step();
    checks++;
    if (con_out !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prestream: out=%b busy=%b required 1 1", con_out, busy);
    end
    #2 clr = 1'b1;
    #1;
    checks++;
    if (con_out !== 1'b0 || con_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out=%b vld=%b busy=%b required 0 0 0", con_out, con_valid, busy);
    end
    step();
    clr = 1'b0; con_in = 1'b0;
    step();
    checks++;
    if (con_out !== 1'b0 || con_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: out=%b vld=%b busy=%b required 0 0 0", con_out, con_valid, busy);
    end
    step();
    checks++;
    if (con_valid !== 1'b0 || con_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_stray_valid: vld=%b out=%b required 0 0", con_valid, con_out);
    end
  endtask

  task automatic test_code_sweep();
    logic [31:0] vals [4];
    logic        exp;
    vals[0] = 32'h0; vals[1] = 32'h5; vals[2] = 32'hFFFF_FFFF; vals[3] = 32'h8000_0000;
    for (int v = 0; v < 4; v++) begin
      for (int c = 0; c < 8; c++) begin
        con_in = 1'b1; bus_mux_out = vals[v]; ir_cond = 3'(c);
        exp = ref_eval(vals[v], 3'(c));
        step();
        con_in = 1'b0;
        step();
        checks++;
        if (con_valid !== 1'b1 || con_out !== exp) begin
          errors++;
          $display("FAIL sweep v=%h c=%0d: vld=%b out=%b required 1 %b", vals[v], c, con_valid, con_out, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bv [3];
    logic [2:0]  cv [3];
    logic        ev [3];
    bv[0] = 32'd0; cv[0] = 3'd0; ev[0] = 1'b1;
    bv[1] = 32'd7; cv[1] = 3'd0; ev[1] = 1'b0;
    bv[2] = 32'd7; cv[2] = 3'd1; ev[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      con_in = 1'b1; bus_mux_out = bv[i]; ir_cond = cv[i];
      step();
      if (i > 0) begin
        checks++;
        if (con_valid !== 1'b1 || con_out !== ev[i-1]) begin
          errors++;
          $display("FAIL b2b_%0d: vld=%b out=%b required 1 %b", i-1, con_valid, con_out, ev[i-1]);
        end
      end
    end
    con_in = 1'b0;
    step();
    checks++;
    if (con_valid !== 1'b1 || con_out !== ev[2] || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_2: vld=%b out=%b busy=%b required 1 %b 0", con_valid, con_out, busy, ev[2]);
    end
    step();
    checks++;
    if (con_valid !== 1'b0 || con_out !== ev[2]) begin
      errors++;
      $display("FAIL b2b_tail: vld=%b out=%b required 0 %b", con_valid, con_out, ev[2]);
    end
  endtask

  task automatic test_flush();
    // Establish con_out=1 first.
    con_in = 1'b1; bus_mux_out = 32'd0; ir_cond = 3'd6;
    step(); con_in = 1'b0; step(); step();
    // Capture an entry that would yield 0, flush it on the next edge.
    con_in = 1'b1; bus_mux_out = 32'd5; ir_cond = 3'd7;
    step();
    con_in = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (con_valid !== 1'b0 || con_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill: vld=%b out=%b busy=%b required 0 1 0", con_valid, con_out, busy);
    end
    // Capture and flush on the same edge: nothing taken.
    con_in = 1'b1; flush = 1'b1; ir_cond = 3'd7;
    step();
    idle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_same_busy: busy=%b required 0", busy);
    end
    step();
    checks++;
    if (con_valid !== 1'b0 || con_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_same: vld=%b out=%b required 0 1", con_valid, con_out);
    end
    // Entry already evaluated at the flush edge stays valid.
    con_in = 1'b1; ir_cond = 3'd7;
    step();
    con_in = 1'b0;
    step();
    flush = 1'b1;
    #1;
    checks++;
    if (con_valid !== 1'b1 || con_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_stage2: vld=%b out=%b required 1 0", con_valid, con_out);
    end
    step();
    flush = 1'b0;
  endtask

  task automatic test_legacy();
    con_in = 1'b1; bus_mux_out = 32'd0; ir_cond = 3'b100;
    step(); con_in = 1'b0; step();
    checks++;
    if (leg_valid !== 1'b1 || leg_out !== 1'b1 || con_out !== 1'b0) begin
      errors++;
      $display("FAIL legacy_eq0: leg=%b%b ext=%b required 11 0", leg_valid, leg_out, con_out);
    end
    con_in = 1'b1; bus_mux_out = 32'd5; ir_cond = 3'b100;
    step(); con_in = 1'b0; step();
    checks++;
    if (leg_out !== 1'b0 || con_out !== 1'b1) begin
      errors++;
      $display("FAIL legacy_eq5: leg=%b ext=%b required 0 1", leg_out, con_out);
    end
  endtask

  task automatic test_random();
    logic        prev_cap, prev_res, exp_out, exp_vld, f, ci;
    logic [31:0] b;
    logic [2:0]  c;
    con_in = 1'b1; bus_mux_out = 32'd0; ir_cond = 3'd6;
    step(); con_in = 1'b0; step();
    exp_out = 1'b1; prev_cap = 1'b0; prev_res = 1'b0;
    for (int k = 0; k < 300; k++) begin
      ci = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'h1;
        default: b = $urandom;
      endcase
      c = 3'($urandom_range(0, 7));
      con_in = ci; flush = f; bus_mux_out = b; ir_cond = c;
      step();
      exp_vld = prev_cap && !f;
      if (exp_vld) exp_out = prev_res;
      prev_cap = ci && !f;
      prev_res = ref_eval(b, c);
      checks++;
      if (con_valid !== exp_vld || con_out !== exp_out || busy !== prev_cap) begin
        errors++;
        $display("FAIL random_%0d: vld=%b out=%b busy=%b required %b %b %b",
                 k, con_valid, con_out, busy, exp_vld, exp_out, prev_cap);
      end
    end
    idle();
    step(); step();
  endtask

  task automatic test_stats();
    clr = 1'b1; step(); clr = 1'b0; step();
`ifdef CON_STATS_EN
    con_in = 1'b1; bus_mux_out = 32'd0; ir_cond = 3'd6;
    for (int i = 0; i < 3; i++) step();
    ir_cond = 3'd7;
    for (int i = 0; i < 2; i++) step();
    con_in = 1'b0;
    step();
    checks++;
    if (eval_cnt !== 4'd5 || taken_cnt !== 4'd3) begin
      errors++;
      $display("FAIL stats_mid: eval=%0d taken=%0d required 5 3", eval_cnt, taken_cnt);
    end
    flush = 1'b1; step(); flush = 1'b0;
    checks++;
    if (eval_cnt !== 4'd5 || taken_cnt !== 4'd3) begin
      errors++;
      $display("FAIL stats_flush: eval=%0d taken=%0d required 5 3", eval_cnt, taken_cnt);
    end
    clr = 1'b1; step(); clr = 1'b0;
    con_in = 1'b1; ir_cond = 3'd6;
    for (int i = 0; i < 20; i++) step();
    con_in = 1'b0;
    step(); step();
    checks++;
    if (eval_cnt !== 4'd15 || taken_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stats_sat: eval=%0d taken=%0d required 15 15", eval_cnt, taken_cnt);
    end
    clr = 1'b1; #1;
    checks++;
    if (eval_cnt !== 4'd0 || taken_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stats_clr: eval=%0d taken=%0d required 0 0", eval_cnt, taken_cnt);
    end
    step(); clr = 1'b0;
`else
    con_in = 1'b1; bus_mux_out = 32'd0; ir_cond = 3'd6;
    for (int i = 0; i < 20; i++) step();
    con_in = 1'b0;
    step(); step();
    checks++;
    if (eval_cnt !== 4'd0 || taken_cnt !== 4'd0 || con_out !== 1'b1) begin
      errors++;
      $display("FAIL stats_off: eval=%0d taken=%0d out=%b required 0 0 1", eval_cnt, taken_cnt, con_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_code_sweep();
    test_back_to_back();
    test_flush();
    test_legacy();
    test_random();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/con_eval_unit.md
Name: con_eval_unit

Overview:
Parametrised, pipelined branch-condition unit for the datapath CON path. It samples the bus value and IR condition field on a con_in strobe, evaluates one of eight conditions over DATA_W bits, and drives a registered, held con_out to the control unit. It adds two-stage pipelining, a valid strobe, a synchronous flush, and an extended condition set to the single-flop CON logic.

Parameters:
DATA_W, 32, width of the bus operand
EXT_COND, 1, 1 = full 3-bit condition set; 0 = ir_cond[2] treated as 0 (legacy 4-code set)
STAT_W, 16, width of the statistics counters (used only with CON_STATS_EN)

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous, active-high reset
con_in  input  1  capture strobe; samples bus_mux_out and ir_cond this edge
bus_mux_out  input  DATA_W  operand from the bus mux
ir_cond  input  3  condition code from the IR (C2 field)
flush  input  1  synchronous pipeline kill
con_out  output  1  registered branch decision, held between updates
con_valid  output  1  one-cycle pulse when con_out is updated
busy  output  1  high while any evaluation is in flight
taken_cnt  output  STAT_W  taken-decision count (CON_STATS_EN only)
eval_cnt  output  STAT_W  total-evaluation count (CON_STATS_EN only)

Behaviour:
- Reset (clr=1, async): s1_valid=0, s2 update suppressed, con_out=0, con_valid=0, busy=0, counters=0. Asserting clr mid-operation discards in-flight work. No con_valid follows reset.
- Stage 1 (edge N, con_in=1): latch operand, code (bit2 forced 0 when EXT_COND=0), s1_valid<=1. If con_in=0, s1_valid<=0.
- Stage 2 (edge N+1, s1_valid=1): con_out<=eval(operand,code) and con_valid<=1. Otherwise con_valid<=0 and con_out holds.
- Latency: con_out and con_valid change at the second edge after the con_in edge. Throughput: one evaluation per cycle; back-to-back con_in yields back-to-back con_valid in order.
- busy = s1_valid (combinational from register).
- Evaluation. Zero is the DATA_W-bit NOR; neg is bit DATA_W-1 (two's complement).
  - 000 EQ: zero
  - 001 NE: !zero
  - 010 GE: !neg
  - 011 LT: neg
  - 100 GT: !neg & !zero
  - 101 LE: neg | zero
  - 110 ALWAYS: 1
  - 111 NEVER: 0
- Boundaries: 0x8000_0000 is negative (LT true, GE false). 0 gives GE true and GT false.
- flush=1 at edge N: s1_valid<=0, and no con_valid results from the killed entry. con_out holds its last value.
- flush and con_in together: flush wins. Nothing is captured.
- An entry already in stage 2 at the flush edge still completes. Flush kills only stage 1.

Optional Feature:
CON_STATS_EN:
- Defined: on every con_valid update, eval_cnt increments and taken_cnt increments if the new con_out=1.
- Both counters saturate at all-ones and never wrap. clr zeroes them; flush does not affect them.
- Undefined: taken_cnt and eval_cnt are tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset: clr pulse mid-stream with con_in asserted -> con_out=0, con_valid=0, busy=0 immediately and on the next edges, no stray valid.
- Code sweep: for bus values {0, 5, 0xFFFF_FFFF, 0x8000_0000} and codes 0-7 -> con_out matches the table, e.g. 0x8000_0000/GE=0, 0/LE=1, 5/GT=1, 0/NE=0, any/NEVER=0.
- Pipelining: con_in high 3 consecutive cycles with (0,EQ), (7,EQ), (7,NE) -> con_valid high cycles N+2..N+4, con_out 1,0,1, busy deasserted after the last capture clears.
- Flush: con_in at N with (0,EQ), flush at N+1 -> no con_valid at N+2 and con_out unchanged. Separately, con_in and flush on the same edge -> nothing captured.
- Legacy: EXT_COND=0, ir_cond=3'b100 with bus=0 -> evaluated as EQ, con_out=1.
- Stats (CON_STATS_EN, STAT_W=4): 20 ALWAYS evaluations -> taken_cnt=eval_cnt=15, saturated. Undefined build -> both counters read 0.
